// File: rtl/bus_ready_delay_pkg.sv
// Shared definitions for the bus_ready_delay skid slice: state encoding,
// default data width and a small state-decoding helper.
package bus_ready_delay_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Encoding 2'd3 is deliberately left unused; the FSM recovers from it to EMPTY.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    function automatic logic holds_beat(input state_t s);
        return (s == BUSY) || (s == FULL);
    endfunction

endpackage

// File: rtl/bus_en_reg.sv
// Width-parameterised load-enable register with synchronous active-low reset.
module bus_en_reg
    import bus_ready_delay_pkg::*;
#(
    parameter int Width = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/bus_ready_delay.sv
// Two-entry skid slice: the main register drives data_o, the skid register
// catches the one beat that can arrive while downstream stalls.
module bus_ready_delay
    import bus_ready_delay_pkg::*;
#(
    parameter int Width = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] data_o
);

    state_t           state_reg;
    state_t           state_next;
    logic             valid_reg;
    logic             valid_next;
    logic             ready_reg;
    logic             ready_next;
    logic             up_hs;
    logic             dn_hs;
    logic             main_en;
    logic             skid_en;
    logic [Width-1:0] main_d;
    logic [Width-1:0] main_q;
    logic [Width-1:0] skid_q;

    assign up_hs   = valid_i && ready_reg;
    assign dn_hs   = valid_reg && ready_i;
    assign ready_o = ready_reg;
    assign valid_o = valid_reg;
    assign data_o  = main_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= EMPTY;
            valid_reg <= 1'b0;
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            valid_reg <= valid_next;
            ready_reg <= ready_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY: if (up_hs) state_next = BUSY;
            BUSY: begin
                if (up_hs && !dn_hs) begin
                    state_next = FULL;
                end else if (!up_hs && dn_hs) begin
                    state_next = EMPTY;
                end
            end
            FULL:    if (ready_i) state_next = BUSY;
            default: state_next = EMPTY;
        endcase
    end

    // ready/valid are computed from the next state so both leave flops directly.
    always_comb begin
        main_en    = 1'b0;
        skid_en    = 1'b0;
        main_d     = data_i;
        valid_next = holds_beat(state_next);
        ready_next = (state_next != FULL);
        case (state_reg)
            EMPTY: main_en = up_hs;
            BUSY: begin
                main_en = up_hs && dn_hs;
                skid_en = up_hs && !dn_hs;
            end
            FULL: begin
                main_en = ready_i;
                main_d  = skid_q;
            end
            default: ;
        endcase
    end

    bus_en_reg #(.Width(Width)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (main_en),
        .d     (main_d),
        .q     (main_q)
    );

    bus_en_reg #(.Width(Width)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (skid_en),
        .d     (data_i),
        .q     (skid_q)
    );

endmodule

// File: tb/tb_bus_ready_delay.sv
// Scoreboard bench for bus_ready_delay: accepted beats are queued by the
// driver and popped by an independent monitor on each downstream handshake.
module tb_bus_ready_delay;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         valid_i;
    logic         ready_o;
    logic [W-1:0] data_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] data_o;

    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    bit           last_acc;

    bus_ready_delay #(.Width(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; an upstream handshake seen before the edge queues its beat.
    task automatic cycle();
        @(negedge clk);
        last_acc = rst_n && valid_i && ready_o;
        if (last_acc) exp_q.push_back(data_i);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops on every downstream handshake and checks stall stability.
    initial begin
        bit           stall = 1'b0;
        logic [W-1:0] stall_data = '0;
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    n_checks++;
                    if (!valid_o || data_o !== stall_data) begin
                        n_fail++;
                        $display("FAIL stall_hold: got valid=%0b data=%0h expected valid=1 data=%0h",
                                 valid_o, data_o, stall_data);
                    end
                end
                if (valid_o && ready_i) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_beat: got data=%0h expected no beat", data_o);
                    end else begin
                        e = exp_q.pop_front();
                        if (data_o !== e) begin
                            n_fail++;
                            $display("FAIL beat_data: got %0h expected %0h", data_o, e);
                        end
                    end
                end
                stall      = valid_o && !ready_i;
                stall_data = data_o;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           sent;
        int           cyc;
        logic [W-1:0] nd;

        rst_n   = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        data_i  = '0;
        repeat (3) cycle();
        check("reset_valid", valid_o, 0);
        check("reset_ready", ready_o, 0);
        check("reset_data", data_o, 0);

        // Release reset with a beat already offered; it waits for ready_o.
        valid_i = 1'b1;
        data_i  = 8'hA5;
        rst_n   = 1'b1;
        check("release_ready_low", ready_o, 0);
        cycle();
        check("release_no_accept", last_acc, 0);
        check("release_ready_high", ready_o, 1);
        check("release_valid_low", valid_o, 0);
        cycle();
        check("a5_accepted", last_acc, 1);
        check("a5_latency_valid", valid_o, 1);
        check("a5_data", data_o, 8'hA5);
        valid_i = 1'b0;
        ready_i = 1'b1;
        cycle();
        check("a5_drained", valid_o, 0);

        // Streaming at one beat per cycle.
        for (int i = 1; i <= 16; i++) begin
            valid_i = 1'b1;
            data_i  = 8'(i);
            cycle();
            check($sformatf("stream_valid_%0d", i), valid_o, 1);
            check($sformatf("stream_data_%0d", i), data_o, i);
        end
        valid_i = 1'b0;
        cycle();
        check("stream_empty", valid_o, 0);

        // Fill to FULL, offer a beat that must be refused, then drain.
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 8'h11;
        cycle();
        data_i  = 8'h22;
        cycle();
        check("full_ready", ready_o, 0);
        check("full_valid", valid_o, 1);
        check("full_data", data_o, 8'h11);
        data_i  = 8'h33;
        cycle();
        check("full_refuse", last_acc, 0);
        check("full_hold_data", data_o, 8'h11);
        valid_i = 1'b0;
        ready_i = 1'b1;
        cycle();
        check("drain_data_22", data_o, 8'h22);
        check("drain_ready", ready_o, 1);
        cycle();
        check("drain_empty", valid_o, 0);

        // Reset while FULL discards both held beats.
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 8'h44;
        cycle();
        data_i  = 8'h55;
        cycle();
        check("prereset_full", ready_o, 0);
        valid_i = 1'b0;
        rst_n   = 1'b0;
        exp_q.delete();
        cycle();
        check("midreset_valid", valid_o, 0);
        check("midreset_data", data_o, 0);
        check("midreset_ready", ready_o, 0);
        rst_n   = 1'b1;
        ready_i = 1'b1;
        cycle();
        check("postreset_ready", ready_o, 1);
        repeat (3) cycle();
        check("postreset_empty", valid_o, 0);

        // Random 50% valid/ready traffic with sequential data.
        sent = 0;
        cyc  = 0;
        nd   = 8'h60;
        while (sent < 1000 && cyc < 8000) begin
            valid_i = 1'($urandom_range(0, 1));
            ready_i = 1'($urandom_range(0, 1));
            data_i  = nd;
            cycle();
            if (last_acc) begin
                sent++;
                nd++;
            end
            cyc++;
        end
        check("random_beats_sent", sent, 1000);
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (4) cycle();
        check("final_queue_empty", exp_q.size(), 0);
        check("final_valid", valid_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
